// File: rtl/cam_line_pkg.sv
// Shared types and default dimensions for the camera line buffer.
package cam_line_pkg;
    localparam int DEF_LINE_W = 1024;
    localparam int DEF_ADDR_W = 10;
    localparam int IDX_W      = 12;
    localparam int FID_W      = 8;
    localparam int PIX_W      = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_READING
    } bank_state_t;

    function automatic logic [PIX_W-1:0] swap_bytes(input logic [PIX_W-1:0] pix);
        return {pix[7:0], pix[15:8]};
    endfunction
endpackage

// File: rtl/cam_line_buffer_if.sv
// Pixel capture and line read-out signals of cam_line_buffer.
// master is the buffer itself, slave is the camera/packet-builder side.
interface cam_line_buffer_if #(parameter int ADDR_W = cam_line_pkg::DEF_ADDR_W);
    import cam_line_pkg::*;

    logic               i_vsync;
    logic               i_de;
    logic               i_pix_vld;
    logic [PIX_W-1:0]   i_pix_data;
    logic               o_line_rdy;
    logic [ADDR_W:0]    o_line_len;
    logic [IDX_W-1:0]   o_line_idx;
    logic [FID_W-1:0]   o_frame_id;
    logic               i_rd_start;
    logic               o_rd_vld;
    logic [PIX_W-1:0]   o_rd_data;
    logic               o_rd_last;
    logic               i_rd_rdy;
    logic [15:0]        o_drop_cnt;

    modport master (
        input  i_vsync, i_de, i_pix_vld, i_pix_data, i_rd_start, i_rd_rdy,
        output o_line_rdy, o_line_len, o_line_idx, o_frame_id,
               o_rd_vld, o_rd_data, o_rd_last, o_drop_cnt
    );

    modport slave (
        output i_vsync, i_de, i_pix_vld, i_pix_data, i_rd_start, i_rd_rdy,
        input  o_line_rdy, o_line_len, o_line_idx, o_frame_id,
               o_rd_vld, o_rd_data, o_rd_last, o_drop_cnt
    );
endinterface

// File: rtl/cam_line_ram.sv
// Simple dual-port line RAM with a registered (1-cycle) read port.
module cam_line_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/cam_line_buffer.sv
// Ping-pong line capture of RGB565 pixels with a valid/ready line read-out.
// Optional CAM_LINE_BYTESWAP_EN: stream words byte-swapped into network order.
module cam_line_buffer
    import cam_line_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic i_pclk,
    input  logic rst_n,
    cam_line_buffer_if.master bus
);
    localparam logic [ADDR_W:0] LINE_MAX = LINE_W[ADDR_W:0];

    logic de_s, de_q, vs_s, vs_q, vld_s;
    logic [PIX_W-1:0] pix_s;
    logic de_rise, de_fall, vs_rise;

    bank_state_t bank_state [2];
    bank_state_t bank_next [2];
    bank_state_t wr_state;
    logic wr_bank, line_open;
    logic [ADDR_W:0] wr_ptr, pix_addr;
    logic [IDX_W-1:0] line_idx;
    logic [FID_W-1:0] frame_id;
    logic [15:0] drop_cnt;
    logic [ADDR_W:0] meta_len [2];
    logic [IDX_W-1:0] meta_idx [2];
    logic [FID_W-1:0] meta_fid [2];
    logic line_start, line_drop, line_done, filling, pix_we;

    logic line_rdy, offer, accept, pop, last_pop;
    logic rd_active, rd_bank;
    logic [ADDR_W:0] rd_addr, rd_len, issue_addr, issue_len;
    logic issue, issue_bank, issue_last, room;
    logic [2:0] occupancy;
    logic infl_vld, infl_last;
    logic [PIX_W-1:0] ram_rdata [2];
    logic [PIX_W-1:0] fifo_data [2];
    logic [1:0] fifo_last;
    logic fifo_wp, fifo_rp;
    logic [1:0] fifo_cnt;

    // Pixel inputs are delayed alongside de so the first pixel lines up with the line start.
    always_ff @(posedge i_pclk or negedge rst_n) begin
        if (!rst_n) begin
            de_s  <= 1'b0;
            de_q  <= 1'b0;
            vs_s  <= 1'b0;
            vs_q  <= 1'b0;
            vld_s <= 1'b0;
            pix_s <= '0;
        end else begin
            de_s  <= bus.i_de;
            de_q  <= de_s;
            vs_s  <= bus.i_vsync;
            vs_q  <= vs_s;
            vld_s <= bus.i_pix_vld;
            pix_s <= bus.i_pix_data;
        end
    end

    assign de_rise = de_s && !de_q;
    assign de_fall = !de_s && de_q;
    assign vs_rise = vs_s && !vs_q;

    always_comb begin
        wr_state   = bank_state[wr_bank];
        line_start = de_rise && (wr_state == BANK_EMPTY);
        line_drop  = de_rise && (wr_state != BANK_EMPTY);
        filling    = (wr_state == BANK_FILLING) || line_start;
        pix_addr   = line_start ? '0 : wr_ptr;
        pix_we     = filling && de_s && vld_s && (pix_addr < LINE_MAX);
        line_done  = de_fall && (wr_state == BANK_FILLING) && !vs_rise && (wr_ptr != '0);
    end

    // With both banks full, wr_bank always points at the older line.
    always_comb begin
        line_rdy = (bank_state[0] == BANK_FULL || bank_state[1] == BANK_FULL) &&
                   bank_state[0] != BANK_READING && bank_state[1] != BANK_READING;
        if (bank_state[0] == BANK_FULL && bank_state[1] == BANK_FULL)
            offer = wr_bank;
        else
            offer = (bank_state[1] == BANK_FULL);
        accept     = bus.i_rd_start && line_rdy;
        pop        = (fifo_cnt != 2'd0) && bus.i_rd_rdy;
        last_pop   = pop && fifo_last[fifo_rp];
        occupancy  = {1'b0, fifo_cnt} + {2'b00, infl_vld};
        room       = occupancy < (3'd2 + {2'b00, pop});
        issue_bank = accept ? offer : rd_bank;
        issue_addr = accept ? '0 : rd_addr;
        issue_len  = accept ? meta_len[offer] : rd_len;
        issue      = accept || (rd_active && (rd_addr != rd_len) && room);
        issue_last = (issue_addr + 1'b1) == issue_len;
    end

    always_comb begin
        bank_next[0] = bank_state[0];
        bank_next[1] = bank_state[1];
        if (line_start)
            bank_next[wr_bank] = BANK_FILLING;
        if (de_fall && wr_state == BANK_FILLING)
            bank_next[wr_bank] = (wr_ptr != '0) ? BANK_FULL : BANK_EMPTY;
        if (vs_rise && wr_state == BANK_FILLING)
            bank_next[wr_bank] = BANK_EMPTY;
        if (accept)
            bank_next[offer] = BANK_READING;
        if (last_pop)
            bank_next[rd_bank] = BANK_EMPTY;
    end

    always_ff @(posedge i_pclk or negedge rst_n) begin
        if (!rst_n) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
        end else begin
            bank_state[0] <= bank_next[0];
            bank_state[1] <= bank_next[1];
        end
    end

    // A line cut short by vsync does not advance line_idx when de finally falls.
    always_ff @(posedge i_pclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank     <= 1'b0;
            wr_ptr      <= '0;
            line_open   <= 1'b0;
            line_idx    <= '0;
            frame_id    <= '0;
            drop_cnt    <= '0;
            meta_len[0] <= '0;
            meta_len[1] <= '0;
            meta_idx[0] <= '0;
            meta_idx[1] <= '0;
            meta_fid[0] <= '0;
            meta_fid[1] <= '0;
        end else begin
            if (line_start)
                wr_ptr <= {{ADDR_W{1'b0}}, pix_we};
            else if (pix_we)
                wr_ptr <= wr_ptr + 1'b1;
            if (line_done) begin
                meta_len[wr_bank] <= wr_ptr;
                meta_idx[wr_bank] <= line_idx;
                meta_fid[wr_bank] <= frame_id;
                wr_bank           <= ~wr_bank;
            end
            if (de_rise)
                line_open <= 1'b1;
            else if (de_fall || vs_rise)
                line_open <= 1'b0;
            if (vs_rise) begin
                frame_id <= frame_id + 1'b1;
                line_idx <= '0;
            end else if (de_fall && line_open) begin
                line_idx <= line_idx + 1'b1;
            end
            if (line_drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Reads are issued only while the in-flight word plus the skid FIFO has room.
    always_ff @(posedge i_pclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_active    <= 1'b0;
            rd_bank      <= 1'b0;
            rd_addr      <= '0;
            rd_len       <= '0;
            infl_vld     <= 1'b0;
            infl_last    <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            fifo_wp      <= 1'b0;
            fifo_rp      <= 1'b0;
            fifo_cnt     <= '0;
        end else begin
            if (accept) begin
                rd_active <= 1'b1;
                rd_bank   <= offer;
                rd_len    <= meta_len[offer];
                rd_addr   <= {{ADDR_W{1'b0}}, 1'b1};
            end else begin
                if (issue)
                    rd_addr <= rd_addr + 1'b1;
                if (last_pop)
                    rd_active <= 1'b0;
            end
            infl_vld  <= issue;
            infl_last <= issue_last;
            if (infl_vld) begin
                fifo_data[fifo_wp] <= ram_rdata[rd_bank];
                fifo_last[fifo_wp] <= infl_last;
                fifo_wp            <= ~fifo_wp;
            end
            if (pop)
                fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + {1'b0, infl_vld} - {1'b0, pop};
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cam_line_ram #(
            .DEPTH (LINE_W),
            .ADDR_W(ADDR_W),
            .DATA_W(PIX_W)
        ) u_ram (
            .clk  (i_pclk),
            .we   (pix_we && (wr_bank == 1'(b))),
            .waddr(pix_addr[ADDR_W-1:0]),
            .wdata(pix_s),
            .re   (issue && (issue_bank == 1'(b))),
            .raddr(issue_addr[ADDR_W-1:0]),
            .rdata(ram_rdata[b])
        );
    end

    assign bus.o_line_rdy = line_rdy;
    assign bus.o_line_len = line_rdy ? meta_len[offer] : '0;
    assign bus.o_line_idx = line_rdy ? meta_idx[offer] : '0;
    assign bus.o_frame_id = line_rdy ? meta_fid[offer] : '0;
    assign bus.o_rd_vld   = (fifo_cnt != 2'd0);
    assign bus.o_rd_last  = (fifo_cnt != 2'd0) && fifo_last[fifo_rp];
    assign bus.o_drop_cnt = drop_cnt;
`ifdef CAM_LINE_BYTESWAP_EN
    assign bus.o_rd_data = swap_bytes(fifo_data[fifo_rp]);
`else
    assign bus.o_rd_data = fifo_data[fifo_rp];
`endif
endmodule

// File: tb/tb_cam_line_buffer.sv
// Randomized bench for cam_line_buffer against a queue-based model of captured lines.
module tb_cam_line_buffer;
    import cam_line_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cam_line_buffer_if bus ();

    cam_line_buffer dut (
        .i_pclk(clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int num_checks = 0;
    int num_errors = 0;

    // Model: stored lines in capture order, their pixels as one flat queue.
    int m_frame = 0;
    int m_line  = 0;
    int m_drop  = 0;
    int len_q[$];
    int idx_q[$];
    int fid_q[$];
    logic [15:0] pix_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [15:0] p);
`ifdef CAM_LINE_BYTESWAP_EN
        return {p[7:0], p[15:8]};
`else
        return p;
`endif
    endfunction

    // Drives one line of npix pixels; abort_at >= 0 raises vsync after that many pixels.
    task automatic applyStimulus(input int npix, input int abort_at, input bit fixed);
        logic [15:0] cur[$];
        logic [15:0] pix;
        bit taken;
        bit open;
        int sent;
        @(negedge clk);
        bus.i_de = 1'b1;
        taken = (len_q.size() < 2);
        open = 1'b1;
        if (!taken && m_drop < 65535) m_drop++;
        sent = 0;
        while (sent < npix) begin
            if (sent == abort_at && open) begin
                bus.i_pix_vld = 1'b0;
                bus.i_vsync = 1'b1;
                m_frame = (m_frame + 1) % 256;
                m_line = 0;
                taken = 1'b0;
                open = 1'b0;
                cur.delete();
                @(negedge clk);
                bus.i_vsync = 1'b0;
                @(negedge clk);
            end else if ($urandom_range(3) != 0) begin
                pix = fixed ? 16'hF81F : 16'($urandom);
                bus.i_pix_vld = 1'b1;
                bus.i_pix_data = pix;
                if (taken && sent < DEF_LINE_W) cur.push_back(pix);
                sent++;
                @(negedge clk);
            end else begin
                bus.i_pix_vld = 1'b0;
                @(negedge clk);
            end
        end
        bus.i_pix_vld = 1'b0;
        bus.i_de = 1'b0;
        if (open) begin
            if (taken && cur.size() > 0) begin
                len_q.push_back(cur.size());
                idx_q.push_back(m_line);
                fid_q.push_back(m_frame);
                foreach (cur[i]) pix_q.push_back(cur[i]);
            end
            m_line = (m_line + 1) % 4096;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_vsync();
        @(negedge clk);
        bus.i_vsync = 1'b1;
        m_frame = (m_frame + 1) % 256;
        m_line = 0;
        @(negedge clk);
        bus.i_vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Reads every line the model holds; rdy_hold keeps i_rd_rdy high throughout.
    task automatic read_lines(input bit rdy_hold);
        int wait_cyc, lat, words, len, cyc;
        logic [15:0] prev_data;
        logic [15:0] exp;
        bit prev_stall;
        while (len_q.size() > 0) begin
            wait_cyc = 0;
            while (!bus.o_line_rdy && wait_cyc < 20) begin
                @(negedge clk);
                wait_cyc++;
            end
            checkOutput("line_rdy", 32'(bus.o_line_rdy), 32'd1);
            if (!bus.o_line_rdy) return;
            len = len_q.pop_front();
            checkOutput("line_len", 32'(bus.o_line_len), 32'(len));
            checkOutput("line_idx", 32'(bus.o_line_idx), 32'(idx_q.pop_front()));
            checkOutput("frame_id", 32'(bus.o_frame_id), 32'(fid_q.pop_front()));
            bus.i_rd_start = 1'b1;
            @(negedge clk);
            bus.i_rd_start = 1'b0;
            lat = 1;
            while (!bus.o_rd_vld && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checkOutput("rd_latency", 32'(lat), 32'd2);
            checkOutput("line_rdy_busy", 32'(bus.o_line_rdy), 32'd0);
            words = 0;
            cyc = 0;
            prev_stall = 1'b0;
            prev_data = '0;
            while (words < len && cyc < 8 * len + 20) begin
                if (prev_stall) checkOutput("rd_hold", 32'(bus.o_rd_data), 32'(prev_data));
                bus.i_rd_rdy = rdy_hold ? 1'b1 : ($urandom_range(2) != 0);
                prev_stall = bus.o_rd_vld && !bus.i_rd_rdy;
                prev_data = bus.o_rd_data;
                if (bus.o_rd_vld && bus.i_rd_rdy) begin
                    exp = pix_q.pop_front();
                    checkOutput("rd_data", 32'(bus.o_rd_data), 32'(exp_word(exp)));
                    checkOutput("rd_last", 32'(bus.o_rd_last), 32'(words == len - 1));
                    words++;
                end
                @(negedge clk);
                cyc++;
            end
            checkOutput("rd_words", 32'(words), 32'(len));
            if (rdy_hold) checkOutput("rd_cycles", 32'(cyc), 32'(len));
            bus.i_rd_rdy = 1'b0;
            checkOutput("rdy_after", 32'(bus.o_line_rdy), 32'(len_q.size() > 0));
            checkOutput("vld_after", 32'(bus.o_rd_vld), 32'd0);
        end
    endtask

    initial begin
        int n;
        int plen;
        int wait_cyc;
        bus.i_vsync = 1'b0;
        bus.i_de = 1'b0;
        bus.i_pix_vld = 1'b0;
        bus.i_pix_data = '0;
        bus.i_rd_start = 1'b0;
        bus.i_rd_rdy = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_line_rdy", 32'(bus.o_line_rdy), 32'd0);
        checkOutput("rst_rd_vld", 32'(bus.o_rd_vld), 32'd0);
        checkOutput("rst_rd_data", 32'(bus.o_rd_data), 32'd0);
        checkOutput("rst_drop", 32'(bus.o_drop_cnt), 32'd0);
        checkOutput("rst_len", 32'(bus.o_line_len), 32'd0);
        rst_n = 1'b1;

        $display("[TB] 640-pixel line, consumer always ready");
        applyStimulus(640, -1, 1'b0);
        checkOutput("drop_0", 32'(bus.o_drop_cnt), 32'(m_drop));
        read_lines(1'b1);

        $display("[TB] two lines stored, third dropped");
        applyStimulus(20, -1, 1'b0);
        applyStimulus(30, -1, 1'b0);
        applyStimulus(25, -1, 1'b0);
        checkOutput("drop_1", 32'(bus.o_drop_cnt), 32'(m_drop));
        read_lines(1'b0);
        repeat (4) @(negedge clk);
        checkOutput("no_third", 32'(bus.o_line_rdy), 32'd0);

        $display("[TB] over-long line truncated");
        applyStimulus(1030, -1, 1'b0);
        read_lines(1'b1);

        $display("[TB] vsync aborts a filling line");
        applyStimulus(200, 100, 1'b0);
        checkOutput("abort_empty", 32'(bus.o_line_rdy), 32'd0);
        applyStimulus(10, -1, 1'b0);
        read_lines(1'b0);

        $display("[TB] fixed pixel pattern");
        applyStimulus(4, -1, 1'b1);
        read_lines(1'b0);

        $display("[TB] random lines");
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(3, 1);
            for (int l = 0; l < n; l++) begin
                plen = $urandom_range(60, 0);
                if (plen > 5 && $urandom_range(4) == 0)
                    applyStimulus(plen, $urandom_range(plen - 1, 1), 1'b0);
                else
                    applyStimulus(plen, -1, 1'b0);
                if ($urandom_range(3) == 0) pulse_vsync();
            end
            checkOutput("drop_rand", 32'(bus.o_drop_cnt), 32'(m_drop));
            read_lines(1'($urandom_range(1)));
        end

        $display("[TB] reset during a read");
        applyStimulus(30, -1, 1'b0);
        wait_cyc = 0;
        while (!bus.o_line_rdy && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        checkOutput("pre_reset_rdy", 32'(bus.o_line_rdy), 32'd1);
        bus.i_rd_start = 1'b1;
        @(negedge clk);
        bus.i_rd_start = 1'b0;
        bus.i_rd_rdy = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_vld", 32'(bus.o_rd_vld), 32'd0);
        checkOutput("mid_rst_rdy", 32'(bus.o_line_rdy), 32'd0);
        checkOutput("mid_rst_drop", 32'(bus.o_drop_cnt), 32'd0);
        len_q.delete();
        idx_q.delete();
        fid_q.delete();
        pix_q.delete();
        m_frame = 0;
        m_line = 0;
        m_drop = 0;
        bus.i_rd_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_vld", 32'(bus.o_rd_vld), 32'd0);
        applyStimulus(5, -1, 1'b0);
        read_lines(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_errors);
        $finish;
    end
endmodule
